iserdes_error_monitor: RTL

// Consumes the per-lane O_ERROR outputs of the iserdes_sdr_ddr_test array in the board top.
// Per lane: masks errors during a post-reset settle window, keeps a sticky error flag and a

---
 rtl/iserdes_error_monitor.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/iserdes_error_monitor.sv
// iserdes_error_monitor
//   Watches the per-lane error levels of the ISERDES test array. After reset or a clear, errors
//   are masked for a settle window; afterwards each lane keeps a sticky flag and a saturating
//   count of error cycles. A periodic sweep streams one {lane, count} word per lane over a
//   valid/ready interface.
// Ports
//   CLK       system clock, all logic on posedge
//   RST_N     asynchronous active-low reset
//   I_CLEAR   synchronous level clear of counters/sticky flags, restarts the settle window
//   I_ERROR   per-lane error level (CLK domain)
//   O_STICKY  per-lane sticky error flag
//   O_LOCKED  settle finished and no lane has seen an error
//   O_DAT     status word {lane[7:0], count}
//   O_VALID   O_DAT valid
//   I_READY   downstream accepts O_DAT when O_VALID & I_READY
module iserdes_error_monitor #(
  parameter int unsigned LANES         = 10,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned REPORT_PERIOD = 2**20
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   I_CLEAR,
  input  logic [LANES-1:0]       I_ERROR,
  output logic [LANES-1:0]       O_STICKY,
  output logic                   O_LOCKED,
  output logic [8+CNT_WIDTH-1:0] O_DAT,
  output logic                   O_VALID,
  input  logic                   I_READY
);

  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TMR_W  = $clog2(REPORT_PERIOD + 1);

  localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SET_W-1:0]     SET_ONE     = SET_W'(1);
  localparam logic [TMR_W-1:0]     TMR_RELOAD  = TMR_W'(REPORT_PERIOD);
  localparam logic [TMR_W-1:0]     TMR_ONE     = TMR_W'(1);
  localparam logic [LANE_W-1:0]    LANE_LAST   = LANE_W'(LANES - 1);
  localparam logic [LANE_W-1:0]    LANE_ONE    = LANE_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  typedef enum logic {
    MON_SETTLE  = 1'b0,
    MON_MONITOR = 1'b1
  } mon_state_e;

  typedef enum logic [1:0] {
    RPT_WAIT = 2'd0,
    RPT_LOAD = 2'd1,
    RPT_SEND = 2'd2
  } rpt_state_e;

  logic [LANES-1:0]       err_q;
  mon_state_e             mon_state_q, mon_state_d;
  logic [SET_W-1:0]       settle_cnt_q, settle_cnt_d;
  logic [CNT_WIDTH-1:0]   cnt_q [LANES];
  logic [CNT_WIDTH-1:0]   cnt_d [LANES];
  logic [LANES-1:0]       sticky_q, sticky_d;
  logic                   locked_q, locked_d;
  rpt_state_e             rpt_state_q, rpt_state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [8+CNT_WIDTH-1:0] dat_q, dat_d;
  logic                   valid_q, valid_d;

  // Input register: all monitoring works on this copy of I_ERROR.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_q <= {LANES{1'b0}};
    end else begin
      err_q <= I_ERROR;
    end
  end

  // Monitor FSM next state: settle window countdown, clear restarts it and wins over everything.
  always_comb begin
    mon_state_d  = mon_state_q;
    settle_cnt_d = settle_cnt_q;
    case (mon_state_q)
      MON_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          mon_state_d  = MON_MONITOR;
          settle_cnt_d = {SET_W{1'b0}};
        end else begin
          settle_cnt_d = settle_cnt_q + SET_ONE;
        end
      end
      MON_MONITOR: begin
        mon_state_d = MON_MONITOR;
      end
      default: begin
        mon_state_d  = MON_SETTLE;
        settle_cnt_d = {SET_W{1'b0}};
      end
    endcase
    if (I_CLEAR) begin
      mon_state_d  = MON_SETTLE;
      settle_cnt_d = {SET_W{1'b0}};
    end else begin
      mon_state_d = mon_state_d;
    end
  end

  // Per-lane counters and sticky flags: held at zero outside MONITOR, saturate at all-ones.
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    for (int i = 0; i < int'(LANES); i++) begin
      if (I_CLEAR || (mon_state_q != MON_MONITOR)) begin
        cnt_d[i]    = {CNT_WIDTH{1'b0}};
        sticky_d[i] = 1'b0;
      end else if (err_q[i]) begin
        sticky_d[i] = 1'b1;
        if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
    locked_d = (mon_state_q == MON_MONITOR) && (sticky_q == {LANES{1'b0}});
  end

  // Report FSM next state: idle countdown, then one LOAD/SEND pair per lane in ascending order.
  always_comb begin
    rpt_state_d = rpt_state_q;
    timer_d     = timer_q;
    lane_d      = lane_q;
    dat_d       = dat_q;
    valid_d     = valid_q;
    case (rpt_state_q)
      RPT_WAIT: begin
        if (timer_q == TMR_ONE) begin
          rpt_state_d = RPT_LOAD;
          lane_d      = {LANE_W{1'b0}};
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      RPT_LOAD: begin
        dat_d       = {8'(lane_q), cnt_q[lane_q]};
        valid_d     = 1'b1;
        rpt_state_d = RPT_SEND;
      end
      RPT_SEND: begin
        // Word stays frozen until it is accepted.
        if (valid_q && I_READY) begin
          valid_d = 1'b0;
          if (lane_q == LANE_LAST) begin
            rpt_state_d = RPT_WAIT;
            timer_d     = TMR_RELOAD;
          end else begin
            lane_d      = lane_q + LANE_ONE;
            rpt_state_d = RPT_LOAD;
          end
        end else begin
          valid_d = valid_q;
        end
      end
      default: begin
        rpt_state_d = RPT_WAIT;
        timer_d     = TMR_RELOAD;
        valid_d     = 1'b0;
      end
    endcase
  end

  // State registers for both FSMs, counters and the registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mon_state_q  <= MON_SETTLE;
      settle_cnt_q <= {SET_W{1'b0}};
      for (int i = 0; i < int'(LANES); i++) begin
        cnt_q[i] <= {CNT_WIDTH{1'b0}};
      end
      sticky_q     <= {LANES{1'b0}};
      locked_q     <= 1'b0;
      rpt_state_q  <= RPT_WAIT;
      timer_q      <= TMR_RELOAD;
      lane_q       <= {LANE_W{1'b0}};
      dat_q        <= {(8 + CNT_WIDTH){1'b0}};
      valid_q      <= 1'b0;
    end else begin
      mon_state_q  <= mon_state_d;
      settle_cnt_q <= settle_cnt_d;
      for (int i = 0; i < int'(LANES); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sticky_q     <= sticky_d;
      locked_q     <= locked_d;
      rpt_state_q  <= rpt_state_d;
      timer_q      <= timer_d;
      lane_q       <= lane_d;
      dat_q        <= dat_d;
      valid_q      <= valid_d;
    end
  end

  assign O_STICKY = sticky_q;
  assign O_LOCKED = locked_q;
  assign O_DAT    = dat_q;
  assign O_VALID  = valid_q;

endmodule
